// File: rtl/modulo_contador_sync_param_if.sv
// rtl/modulo_contador_sync_param_if.sv - control/status bundle for the modulo counter
interface modulo_contador_sync_param_if #(
  parameter int WIDTH = 7
);
  logic             load;
  logic [WIDTH-1:0] e;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;
  logic             wrap;

  modport master (output load, e, en, up, input q, q_bar, tc, wrap);
  modport slave  (input load, e, en, up, output q, q_bar, tc, wrap);
endinterface

// File: rtl/modulo_contador_sync_param.sv
// rtl/modulo_contador_sync_param.sv - up/down modulo counter with saturating load and wrap flags
module modulo_contador_sync_param #(
  parameter int WIDTH     = 7,
  parameter int MODULO    = 100,
  parameter int RESET_VAL = 0
) (
  input  logic                         clk,
  input  logic                         clr,
  modulo_contador_sync_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             e_in_range;
  logic             at_last, at_zero;

  // Extra bit lets MODULO == 2**WIDTH compare correctly.
  assign e_in_range = ({1'b0, bus.e} < MOD_EXT);
  assign at_last    = (q_q == LAST);
  assign at_zero    = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = e_in_range ? bus.e : LAST;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_last) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d    = LAST;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.q_bar = ~q_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.en & ~bus.load & (bus.up ? at_last : at_zero);

endmodule

// File: tb/tb_modulo_contador_sync_param.sv
// tb/tb_modulo_contador_sync_param.sv - directed and randomized checks of three counter configurations
module tb_modulo_contador_sync_param;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic        ld [3];
  logic        enn[3];
  logic        upp[3];
  logic [15:0] ee [3];

  wire  [15:0] q_w   [3];
  wire  [15:0] qb_w  [3];
  wire         tc_w  [3];
  wire         wrap_w[3];

  modulo_contador_sync_param_if #(.WIDTH(7)) b0 ();
  modulo_contador_sync_param_if #(.WIDTH(4)) b1 ();
  modulo_contador_sync_param_if #(.WIDTH(2)) b2 ();

  modulo_contador_sync_param #(.WIDTH(7), .MODULO(100), .RESET_VAL(0)) u0 (.clk(clk), .clr(clr), .bus(b0));
  modulo_contador_sync_param #(.WIDTH(4), .MODULO(16),  .RESET_VAL(3)) u1 (.clk(clk), .clr(clr), .bus(b1));
  modulo_contador_sync_param #(.WIDTH(2), .MODULO(2),   .RESET_VAL(0)) u2 (.clk(clk), .clr(clr), .bus(b2));

  assign b0.load = ld[0];  assign b0.en = enn[0];  assign b0.up = upp[0];  assign b0.e = ee[0][6:0];
  assign b1.load = ld[1];  assign b1.en = enn[1];  assign b1.up = upp[1];  assign b1.e = ee[1][3:0];
  assign b2.load = ld[2];  assign b2.en = enn[2];  assign b2.up = upp[2];  assign b2.e = ee[2][1:0];

  assign q_w[0]  = {9'b0, b0.q};      assign q_w[1]  = {12'b0, b1.q};      assign q_w[2]  = {14'b0, b2.q};
  assign qb_w[0] = {9'b0, b0.q_bar};  assign qb_w[1] = {12'b0, b1.q_bar};  assign qb_w[2] = {14'b0, b2.q_bar};
  assign tc_w[0] = b0.tc;    assign tc_w[1] = b1.tc;    assign tc_w[2] = b2.tc;
  assign wrap_w[0] = b0.wrap; assign wrap_w[1] = b1.wrap; assign wrap_w[2] = b2.wrap;

  int modv[3] = '{100, 16, 2};
  int wid [3] = '{7, 4, 2};
  int rstv[3] = '{0, 3, 0};
  int mq  [3];
  int mw  [3];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int idx, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = rstv[i];
      mw[i] = 0;
    end
  endtask

  // Reference: modular arithmetic on integers, wrap = next value fell outside 0..M-1.
  task automatic model_edge();
    int nq;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i] = rstv[i];
        mw[i] = 0;
      end else if (ld[i]) begin
        mq[i] = (int'(ee[i]) < modv[i]) ? int'(ee[i]) : modv[i] - 1;
        mw[i] = 0;
      end else if (enn[i]) begin
        nq    = mq[i] + (upp[i] ? 1 : -1);
        mw[i] = (nq < 0 || nq >= modv[i]) ? 1 : 0;
        mq[i] = (nq + modv[i]) % modv[i];
      end else begin
        mw[i] = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    int exp_tc;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_tc = (enn[i] && !ld[i] && (upp[i] ? (mq[i] == modv[i] - 1) : (mq[i] == 0))) ? 1 : 0;
      chk("tc", i, int'(tc_w[i]), exp_tc);
      chk("q_bar", i, int'(qb_w[i]), (~mq[i]) & ((1 << wid[i]) - 1));
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("q", i, int'(q_w[i]), mq[i]);
      chk("wrap", i, int'(wrap_w[i]), mw[i]);
    end
    @(negedge clk);
  endtask

  task automatic set_in(input int i, input bit l, input int ev, input bit en_v, input bit up_v);
    ld[i]  = l;
    ee[i]  = 16'(ev);
    enn[i] = en_v;
    upp[i] = up_v;
  endtask

  int up_seq[4]   = '{98, 99, 0, 1};
  int up_wrap[4]  = '{0, 0, 1, 0};
  int dn_seq[3]   = '{0, 99, 98};
  int dn_wrap[3]  = '{0, 1, 0};
  int b2b_seq[4]  = '{1, 0, 1, 0};
  int b2b_wrap[4] = '{0, 1, 0, 1};

  initial begin
    for (int i = 0; i < 3; i++) set_in(i, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    set_in(0, 1, 55, 0, 0);
    cycle();

    // Asynchronous reset between edges, then held across three edges.
    clr = 1'b1;
    #1;
    model_reset();
    chk("rst_q", 0, int'(q_w[0]), 0);
    chk("rst_qbar", 0, int'(qb_w[0]), 'h7F);
    chk("rst_wrap", 0, int'(wrap_w[0]), 0);
    chk("rst_q", 1, int'(q_w[1]), 3);
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_hold", 0, int'(q_w[0]), 0);
    end
    clr = 1'b0;
    set_in(0, 0, 0, 0, 0);

    set_in(0, 1, 97, 0, 0);
    cycle();
    chk("load97", 0, int'(q_w[0]), 97);
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("up_seq", 0, int'(q_w[0]), up_seq[k]);
      chk("up_wrap", 0, int'(wrap_w[0]), up_wrap[k]);
    end

    set_in(0, 1, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("dn_seq", 0, int'(q_w[0]), dn_seq[k]);
      chk("dn_wrap", 0, int'(wrap_w[0]), dn_wrap[k]);
    end

    set_in(0, 1, 120, 1, 1);
    cycle();
    chk("sat_load", 0, int'(q_w[0]), 99);
    chk("sat_wrap", 0, int'(wrap_w[0]), 0);
    set_in(0, 1, 42, 1, 0);
    cycle();
    chk("load42", 0, int'(q_w[0]), 42);
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold", 0, int'(q_w[0]), 42);
      chk("hold_tc", 0, int'(tc_w[0]), 0);
    end

    set_in(1, 1, 15, 0, 0);
    cycle();
    set_in(1, 0, 0, 1, 1);
    cycle();
    chk("full_up", 1, int'(q_w[1]), 0);
    chk("full_up_wrap", 1, int'(wrap_w[1]), 1);
    set_in(1, 0, 0, 1, 0);
    cycle();
    chk("full_dn", 1, int'(q_w[1]), 15);
    chk("full_dn_wrap", 1, int'(wrap_w[1]), 1);
    set_in(1, 0, 0, 0, 0);

    set_in(2, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("b2b_seq", 2, int'(q_w[2]), b2b_seq[k]);
      chk("b2b_wrap", 2, int'(wrap_w[2]), b2b_wrap[k]);
    end

    // Randomized mix including occasional mid-count resets.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 3; i++)
        set_in(i, ($urandom_range(7) == 0), int'($urandom_range((1 << wid[i]) - 1)),
               ($urandom_range(3) != 0), 1'($urandom_range(1)));
      if ($urandom_range(39) == 0) begin
        clr = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
          chk("async_q", i, int'(q_w[i]), mq[i]);
          chk("async_wrap", i, int'(wrap_w[i]), 0);
        end
      end else begin
        clr = 1'b0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
